// File: rtl/signed_seq_divider_if.sv
// signed_seq_divider_if: operand request and result bundle for signed_seq_divider
interface signed_seq_divider_if #(parameter int N = 4);
  logic start;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor;
  logic busy;
  logic done;
  logic [2*N-1:0] quotient;
  logic [N-1:0] remainder;
  logic dbz;
  logic ovf;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, dbz, ovf);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, dbz, ovf);
endinterface

// File: rtl/signed_seq_divider.sv
// signed_seq_divider: multicycle signed 2N/N restoring divider truncating toward zero
module signed_seq_divider #(parameter int N = 4) (
  input logic clk,
  input logic rst_n,
  signed_seq_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(2*N+1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] q;
  logic [N:0] r, d, rs;
  logic qneg, rneg, zdiv, ovfl, ge;
  logic [2*N-1:0] qfix;
  logic [N-1:0] rfix;
  always_comb begin
    rs = {r[N-1:0], q[2*N-1]};
    ge = rs >= d;
    qfix = zdiv ? '1 : qneg ? -q : q;
    rfix = zdiv ? '0 : rneg ? N'(-r) : N'(r);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      zdiv <= 1'b0;
      ovfl <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.dbz <= 1'b0;
      bus.ovf <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          state <= CALC;
          cnt <= '0;
          q <= bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
          r <= '0;
          d <= bus.divisor[N-1] ? -{1'b1, bus.divisor} : {1'b0, bus.divisor};
          qneg <= bus.dividend[2*N-1] ^ bus.divisor[N-1];
          rneg <= bus.dividend[2*N-1];
          zdiv <= bus.divisor == '0;
          ovfl <= bus.dividend == {1'b1, {(2*N-1){1'b0}}} && &bus.divisor;
          bus.busy <= 1'b1;
          bus.dbz <= 1'b0;
          bus.ovf <= 1'b0;
        end
        CALC: if (cnt == CW'(2*N)) state <= FIX;
        else begin
          cnt <= cnt + 1'b1;
          r <= ge ? rs - d : rs;
          q <= {q[2*N-2:0], ge};
        end
        FIX: begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.quotient <= qfix;
          bus.remainder <= rfix;
          bus.dbz <= zdiv;
          bus.ovf <= ovfl;
        end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: directed and random checks of signed_seq_divider against an arithmetic model
module tb_signed_seq_divider;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  signed_seq_divider_if #(.N(4)) bus ();
  signed_seq_divider #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic signed [7:0] a, input logic signed [3:0] b, output logic [7:0] q, output logic [3:0] r, output logic z, output logic o);
    int ai, bi;
    ai = a;
    bi = b;
    z = bi == 0;
    o = ai == -128 && bi == -1;
    if (z) begin
      q = 8'hFF;
      r = 4'h0;
    end else if (o) begin
      q = 8'h80;
      r = 4'h0;
    end else begin
      q = 8'(ai / bi);
      r = 4'(ai % bi);
    end
  endfunction
  task automatic op(input logic [7:0] a, input logic [3:0] b, input int poke);
    logic [7:0] eq;
    logic [3:0] er;
    logic ez, eo;
    int lat;
    model($signed(a), $signed(b), eq, er, ez, eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor = 4'($urandom);
    chk("busy_accept", 16'(bus.busy), 16'd1);
    chk("flags_clear", 16'({bus.dbz, bus.ovf}), 16'd0);
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
      if (lat == 5) chk("busy_mid", 16'(bus.busy), 16'd1);
      bus.start = lat == poke;
      if (lat == poke) begin
        bus.dividend = 8'($urandom);
        bus.divisor = 4'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("latency", 16'(lat), 16'd10);
    chk("quotient", 16'(bus.quotient), 16'(eq));
    chk("remainder", 16'(bus.remainder), 16'(er));
    chk("dbz", 16'(bus.dbz), 16'(ez));
    chk("ovf", 16'(bus.ovf), 16'(eo));
    chk("busy_done", 16'(bus.busy), 16'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", 16'(bus.done), 16'd0);
    chk("hold", 16'({bus.quotient, bus.remainder, bus.dbz, bus.ovf}), 16'({eq, er, ez, eo}));
  endtask
  initial begin
    logic seen;
    logic [7:0] ra;
    logic [3:0] rb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #1;
    chk("reset_state", 16'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.ovf}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(8'd100, 4'd7, 0);
    op(8'(-100), 4'd7, 0);
    op(8'd100, 4'(-7), 0);
    op(8'h80, 4'hF, 0);
    op(8'd6, 4'd3, 0);
    op(8'd5, 4'd0, 0);
    op(8'd100, 4'd7, 3);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 16'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz, bus.ovf}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= bus.done;
    end
    chk("no_done_after_abort", 16'(seen), 16'd0);
    op(8'd127, 4'(-8), 0);
    for (int i = 0; i < 40; i++) begin
      ra = (i % 11 == 0) ? 8'h80 : 8'($urandom);
      rb = (i % 7 == 0) ? 4'h0 : (i % 11 == 0) ? 4'hF : 4'($urandom);
      op(ra, rb, (i % 5 == 0) ? 2 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
